// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT unsigned DATA_WIDTH samples into an ACC_WIDTH
// total (modulo 2^ACC_WIDTH) with a sticky carry-out flag, and presents each
// completed total on a valid/ready output port.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. in_ready is 1 while accumulating; while a
// result is held it mirrors out_ready, so a new window can open in the same
// cycle the result is taken. out_data/out_overflow stay stable while out_valid
// is high, and keep their last value after the take; only out_valid qualifies
// them. in_ready is forced low while reset is asserted.
module sum_accumulator #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 8,
    parameter int COUNT      = 4
) (
    input  logic [1:0]            clock_reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_overflow,
    input  logic                  out_ready
);

    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    logic clk;
    logic rst;

    state_t               state;
    state_t               state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic                 ovf;
    logic                 ovf_nxt;
    logic [ACC_WIDTH-1:0] out_data_q;
    logic [ACC_WIDTH-1:0] out_data_nxt;
    logic                 out_ovf_q;
    logic                 out_ovf_nxt;

    logic                 accept;
    logic                 take;
    logic [ACC_WIDTH:0]   sum_ext;
    logic                 sum_ovf;

    assign clk = clock_reset[0];
    assign rst = clock_reset[1];

    // Handshake outputs derived from the current state.
    assign out_valid    = (state == HOLD);
    assign in_ready     = !rst && ((state == ACCUM) || out_ready);
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    // acc/cnt/ovf are cleared on every completion, so while a result is held
    // they already describe an empty window and the same adder serves both
    // a plain accept and an accept in the take cycle.
    assign sum_ext = {1'b0, acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, in_data};
    assign sum_ovf = ovf | sum_ext[ACC_WIDTH];

    // Next-state and datapath update: close a window on its last accept,
    // otherwise fold the sample into the running total.
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        ovf_nxt      = ovf;
        out_data_nxt = out_data_q;
        out_ovf_nxt  = out_ovf_q;

        if (state == ACCUM || take) begin
            state_nxt = ACCUM;
            if (accept) begin
                if (cnt == LAST) begin
                    out_data_nxt = sum_ext[ACC_WIDTH-1:0];
                    out_ovf_nxt  = sum_ovf;
                    acc_nxt      = '0;
                    cnt_nxt      = '0;
                    ovf_nxt      = 1'b0;
                    state_nxt    = HOLD;
                end else begin
                    acc_nxt = sum_ext[ACC_WIDTH-1:0];
                    cnt_nxt = cnt + 1'b1;
                    ovf_nxt = sum_ovf;
                end
            end
        end
    end

    // State register with synchronous reset; reset drops any partial window
    // and any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            ovf        <= ovf_nxt;
            out_data_q <= out_data_nxt;
            out_ovf_q  <= out_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator. Three instances share one stimulus stream:
// index 0 = defaults (W=8, COUNT=4), index 1 = ACC_WIDTH 5, index 2 = COUNT 1.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       out_ready = 1'b0;
    wire  [1:0] clock_reset = {rst, clk};

    wire  [2:0] i_ready;
    wire  [2:0] o_valid;
    wire  [2:0] o_ovf;
    wire  [7:0] a_data;
    wire  [4:0] b_data;
    wire  [7:0] c_data;
    wire  [7:0] o_data [3];

    assign o_data[0] = a_data;
    assign o_data[1] = {3'b000, b_data};
    assign o_data[2] = c_data;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: per instance, the true (unbounded) sum of the open
    // window, its sample count, and the pending result.
    int aw [3] = '{8, 5, 8};
    int cn [3] = '{4, 4, 1};
    int m_pending [3] = '{0, 0, 0};
    int m_data    [3] = '{0, 0, 0};
    int m_ovf     [3] = '{0, 0, 0};
    int m_wsum    [3] = '{0, 0, 0};
    int m_wcnt    [3] = '{0, 0, 0};

    // clock/reset
    always #5 clk = ~clk;

    sum_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .COUNT(4)) dut (
        .clock_reset (clock_reset), .in_valid (in_valid), .in_data (in_data),
        .in_ready (i_ready[0]), .out_valid (o_valid[0]), .out_data (a_data),
        .out_overflow (o_ovf[0]), .out_ready (out_ready)
    );

    sum_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(5), .COUNT(4)) dut_narrow (
        .clock_reset (clock_reset), .in_valid (in_valid), .in_data (in_data),
        .in_ready (i_ready[1]), .out_valid (o_valid[1]), .out_data (b_data),
        .out_overflow (o_ovf[1]), .out_ready (out_ready)
    );

    sum_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .COUNT(1)) dut_single (
        .clock_reset (clock_reset), .in_valid (in_valid), .in_data (in_data),
        .in_ready (i_ready[2]), .out_valid (o_valid[2]), .out_data (c_data),
        .out_overflow (o_ovf[2]), .out_ready (out_ready)
    );

    function automatic logic exp_ready(input int i);
        return !rst && (m_pending[i] == 0 || out_ready);
    endfunction

    // driver: apply inputs and let combinational outputs settle
    task automatic drive(input logic v, input logic [3:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    // advance one clock edge and move the reference model with it
    task automatic step();
        bit acc_now [3];
        bit tk_now  [3];
        for (int i = 0; i < 3; i++) begin
            acc_now[i] = in_valid && exp_ready(i);
            tk_now[i]  = (m_pending[i] != 0) && out_ready;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_pending[i] = 0; m_data[i] = 0; m_ovf[i] = 0;
                m_wsum[i] = 0; m_wcnt[i] = 0;
            end else begin
                if (tk_now[i]) m_pending[i] = 0;
                if (acc_now[i]) begin
                    m_wsum[i] += int'(in_data);
                    m_wcnt[i] += 1;
                    if (m_wcnt[i] == cn[i]) begin
                        m_pending[i] = 1;
                        m_data[i]    = m_wsum[i] % (1 << aw[i]);
                        m_ovf[i]     = (m_wsum[i] >= (1 << aw[i])) ? 1 : 0;
                        m_wsum[i]    = 0;
                        m_wcnt[i]    = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'h9, 1'b1);
        tests_run++;
        if (i_ready !== 3'b000) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 000", i_ready); end
        step();
        step();
        tests_run++;
        if (o_valid !== 3'b000) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 000", o_valid); end
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b0);
        tests_run++;
        if (o_valid[0] !== 1'b0 || o_data[0] !== 8'h00 || o_ovf[0] !== 1'b0 || i_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset: got valid=%b data=%h ovf=%b ready=%b want 0 00 0 1",
                     o_valid[0], o_data[0], o_ovf[0], i_ready[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'd7, 1'b1);
            tests_run++;
            if (o_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL b2b_early_valid[%0d]: got %b want 0", k, o_valid[0]); end
            step();
        end
        drive(1'b0, 4'h0, 1'b1);
        tests_run++;
        if (o_valid[0] !== 1'b1 || o_data[0] !== 8'h1C || o_ovf[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_result: got valid=%b data=%h ovf=%b want 1 1c 0", o_valid[0], o_data[0], o_ovf[0]);
        end
        step();
        tests_run++;
        if (o_valid[0] !== 1'b0 || o_data[0] !== 8'h1C) begin
            tests_failed++;
            $display("FAIL b2b_after_take: got valid=%b data=%h want 0 1c", o_valid[0], o_data[0]);
        end
    endtask

    task automatic test_stall();
        int seq [7] = '{3, -1, 4, -1, -1, 1, 2};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (seq[k] >= 0) drive(1'b1, 4'(seq[k]), 1'b0);
            else             drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
            step();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            tests_run++;
            if (o_valid[0] !== 1'b1 || o_data[0] !== 8'h0A || i_ready[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h ready=%b want 1 0a 0",
                         k, o_valid[0], o_data[0], i_ready[0]);
            end
            step();
        end
        drive(1'b0, 4'h0, 1'b1);
        tests_run++;
        if (o_valid[0] !== 1'b1 || o_data[0] !== 8'h0A || i_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: got valid=%b data=%h ready=%b want 1 0a 1",
                     o_valid[0], o_data[0], i_ready[0]);
        end
        step();
        tests_run++;
        if (o_valid[0] !== 1'b0 || o_data[0] !== 8'h0A) begin
            tests_failed++;
            $display("FAIL stall_taken: got valid=%b data=%h want 0 0a", o_valid[0], o_data[0]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'd15, 1'b1);
            step();
        end
        drive(1'b1, 4'd1, 1'b1);
        tests_run++;
        if (o_valid[1] !== 1'b1 || o_data[1] !== 8'h1C || o_ovf[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_narrow: got valid=%b data=%h ovf=%b want 1 1c 1", o_valid[1], o_data[1], o_ovf[1]);
        end
        tests_run++;
        if (o_data[0] !== 8'h3C || o_ovf[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_wide: got data=%h ovf=%b want 3c 0", o_data[0], o_ovf[0]);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'd1, 1'b1);
            step();
        end
        drive(1'b0, 4'h0, 1'b1);
        tests_run++;
        if (o_valid[1] !== 1'b1 || o_data[1] !== 8'h04 || o_ovf[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_next_window: got valid=%b data=%h ovf=%b want 1 04 0", o_valid[1], o_data[1], o_ovf[1]);
        end
        step();
    endtask

    task automatic test_reset_mid_window();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 4'd5, 1'b1);
            step();
        end
        rst = 1'b1;
        drive(1'b1, 4'd5, 1'b1);
        tests_run++;
        if (i_ready[0] !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_ready: got %b want 0", i_ready[0]); end
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'd1, 1'b1);
            tests_run++;
            if (o_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_spurious[%0d]: got %b want 0", k, o_valid[0]); end
            step();
        end
        drive(1'b0, 4'h0, 1'b1);
        tests_run++;
        if (o_valid[0] !== 1'b1 || o_data[0] !== 8'h04 || o_ovf[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_result: got valid=%b data=%h ovf=%b want 1 04 0", o_valid[0], o_data[0], o_ovf[0]);
        end
        step();
    endtask

    task automatic test_continuous();
        int results = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 4'd2, 1'b1);
            tests_run++;
            if (i_ready[0] !== 1'b1) begin tests_failed++; $display("FAIL cont_ready[%0d]: got %b want 1", k, i_ready[0]); end
            step();
            tests_run++;
            if (o_valid[0] !== ((k % 4) == 3)) begin
                tests_failed++;
                $display("FAIL cont_valid[%0d]: got %b want %b", k, o_valid[0], ((k % 4) == 3));
            end
            if (o_valid[0] === 1'b1) begin
                results++;
                tests_run++;
                if (o_data[0] !== 8'h08) begin tests_failed++; $display("FAIL cont_data[%0d]: got %h want 08", k, o_data[0]); end
            end
            tests_run++;
            if (o_valid[2] !== 1'b1 || o_data[2] !== 8'h02) begin
                tests_failed++;
                $display("FAIL cont_count1[%0d]: got valid=%b data=%h want 1 02", k, o_valid[2], o_data[2]);
            end
        end
        tests_run++;
        if (results != 3) begin tests_failed++; $display("FAIL cont_results: got %0d want 3", results); end
        drive(1'b0, 4'h0, 1'b1);
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (i_ready[i] !== exp_ready(i)) begin
                    tests_failed++;
                    $display("FAIL rand_ready[%0d] inst %0d: got %b want %b", n, i, i_ready[i], exp_ready(i));
                end
            end
            step();
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (o_valid[i] !== (m_pending[i] != 0) || o_data[i] !== 8'(m_data[i]) || o_ovf[i] !== (m_ovf[i] != 0)) begin
                    tests_failed++;
                    $display("FAIL rand_out[%0d] inst %0d: got valid=%b data=%h ovf=%b want %0d %h %0d",
                             n, i, o_valid[i], o_data[i], o_ovf[i], m_pending[i], 8'(m_data[i]), m_ovf[i]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid_window();
        test_continuous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
